// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states and
// the signedness decode used by both the multiplier and the divider.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        MUL   = 4'd2,
        MADD  = 4'd3,
        MADDU = 4'd4,
        MSUB  = 4'd5,
        MSUBU = 4'd6,
        DIV   = 4'd7,
        DIVU  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_signed_op(input mdu_op_t op);
        case (op)
            MULT, MUL, MADD, MSUB, DIV: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative radix-2 non-restoring divider on magnitudes with a trailing
// sign-fix cycle; a zero divisor finishes two cycles after start.
module mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            i_clear,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [XLEN+1:0]  r_acc;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_fix;
    logic             r_dz;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_done;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_rem;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic [XLEN+1:0]  w_d_ext;
    logic [XLEN+1:0]  w_acc_sh;
    logic [XLEN+1:0]  w_acc_nx;
    logic [XLEN+1:0]  w_rem_fix;

    assign w_a_neg   = i_signed & i_dividend[XLEN-1];
    assign w_b_neg   = i_signed & i_divisor[XLEN-1];
    assign w_a_abs   = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs   = w_b_neg ? -i_divisor : i_divisor;
    assign w_d_ext   = {2'b00, r_d};
    assign w_acc_sh  = {r_acc[XLEN:0], r_q[XLEN-1]};
    // Sign of the partial remainder picks add or subtract; no restore step.
    assign w_acc_nx  = r_acc[XLEN+1] ? (w_acc_sh + w_d_ext) : (w_acc_sh - w_d_ext);
    assign w_rem_fix = r_acc[XLEN+1] ? (r_acc + w_d_ext) : r_acc;

    // Divider sequencing: load, XLEN iterations, sign fix, done pulse.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_fix   <= 1'b0;
            r_dz    <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_run <= 1'b0;
                r_fix <= 1'b0;
                r_cnt <= '0;
                if (i_divisor == '0) begin
                    r_dz   <= 1'b1;
                    r_quot <= '1;
                    r_rem  <= i_dividend;
                end else begin
                    r_dz    <= 1'b0;
                    r_run   <= 1'b1;
                    r_acc   <= '0;
                    r_q     <= w_a_abs;
                    r_d     <= w_b_abs;
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                end
            end else if (r_dz) begin
                r_dz   <= 1'b0;
                r_done <= 1'b1;
            end else if (r_run) begin
                r_acc <= w_acc_nx;
                r_q   <= {r_q[XLEN-2:0], ~w_acc_nx[XLEN+1]};
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    r_run <= 1'b0;
                    r_fix <= 1'b1;
                end
            end else if (r_fix) begin
                r_fix  <= 1'b0;
                r_done <= 1'b1;
                r_quot <= r_q_neg ? -r_q : r_q;
                r_rem  <= r_r_neg ? -w_rem_fix[XLEN-1:0] : w_rem_fix[XLEN-1:0];
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_param.sv
// Multiply/divide unit: one op in flight, pipelined multiply-accumulate,
// iterative divide, and a valid/ready result port that holds until taken.
module mdu_param
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MDU_OP_W-1:0] in_op,
    input  logic [XLEN-1:0]     in_src1,
    input  logic [XLEN-1:0]     in_src2,
    input  logic [XLEN-1:0]     in_hi,
    input  logic [XLEN-1:0]     in_lo,
    input  logic [TAG_W-1:0]    in_tag1,
    input  logic [TAG_W-1:0]    in_tag2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MDU_OP_W-1:0] out_op,
    output logic [XLEN-1:0]     out_hi,
    output logic [XLEN-1:0]     out_lo,
    output logic [TAG_W-1:0]    out_tag1,
    output logic [TAG_W-1:0]    out_tag2,
    output logic                busy
);

    localparam int PW    = 2 * XLEN + 2;
    localparam int CNT_W = $clog2(MUL_STAGES + 2);
    localparam logic [CNT_W-1:0] MS_CNT = CNT_W'(MUL_STAGES);

    mdu_state_t          r_state;
    mdu_op_t             r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [TAG_W-1:0]    r_tag1;
    logic [TAG_W-1:0]    r_tag2;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_pipe [MUL_STAGES];
    logic                r_out_valid;
    mdu_op_t             r_out_op;
    logic [XLEN-1:0]     r_out_hi;
    logic [XLEN-1:0]     r_out_lo;
    logic [TAG_W-1:0]    r_out_tag1;
    logic [TAG_W-1:0]    r_out_tag2;

    mdu_op_t             w_op;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_is_div;
    logic                w_m_signed;
    logic [PW-1:0]       w_a_ext;
    logic [PW-1:0]       w_b_ext;
    logic [PW-1:0]       w_prod;
    logic [2*XLEN-1:0]   w_mul_res;
    logic                w_div_done;
    logic [XLEN-1:0]     w_div_quot;
    logic [XLEN-1:0]     w_div_rem;

    // Unknown encodings collapse to MULTU so the unit never traps.
    always_comb begin
        if (in_op > DIVU) begin
            w_op = MULTU;
        end else begin
            w_op = mdu_op_t'(in_op);
        end
    end

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_is_div   = (w_op == DIV) || (w_op == DIVU);

    // Sign- or zero-extend so a single unsigned multiply covers both forms.
    assign w_m_signed = is_signed_op(r_op);
    assign w_a_ext    = {{(XLEN + 2){w_m_signed & r_a[XLEN-1]}}, r_a};
    assign w_b_ext    = {{(XLEN + 2){w_m_signed & r_b[XLEN-1]}}, r_b};
    assign w_prod     = w_a_ext * w_b_ext;

    // Accumulate variants fold HI/LO into the first pipeline stage.
    always_comb begin
        case (r_op)
            MADD, MADDU: w_mul_res = {r_hi, r_lo} + w_prod[2*XLEN-1:0];
            MSUB, MSUBU: w_mul_res = {r_hi, r_lo} - w_prod[2*XLEN-1:0];
            default:     w_mul_res = w_prod[2*XLEN-1:0];
        endcase
    end

    // Multiplier result pipeline.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_mul_res;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    mdu_div_iter #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .i_clear    (reset || flush),
        .i_start    (w_accept && w_is_div),
        .i_signed   (is_signed_op(w_op)),
        .i_dividend (in_src1),
        .i_divisor  (in_src2),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem)
    );

    // Control FSM and registered result port.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state     <= ST_IDLE;
            r_op        <= MULT;
            r_a         <= '0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_op    <= MULT;
            r_out_hi    <= '0;
            r_out_lo    <= '0;
            r_out_tag1  <= '0;
            r_out_tag2  <= '0;
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == MS_CNT) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_op    <= r_op;
                        r_out_hi    <= r_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
                        r_out_lo    <= r_pipe[MUL_STAGES-1][XLEN-1:0];
                        r_out_tag1  <= r_tag1;
                        r_out_tag2  <= r_tag2;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_op    <= r_op;
                        r_out_hi    <= w_div_rem;
                        r_out_lo    <= w_div_quot;
                        r_out_tag1  <= r_tag1;
                        r_out_tag2  <= r_tag2;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A same-cycle accept overrides the DONE->IDLE step above.
            if (w_accept) begin
                r_state <= w_is_div ? ST_DIV : ST_MUL;
                r_op    <= w_op;
                r_a     <= in_src1;
                r_b     <= in_src2;
                r_hi    <= in_hi;
                r_lo    <= in_lo;
                r_tag1  <= in_tag1;
                r_tag2  <= in_tag2;
                r_cnt   <= '0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_hi    = r_out_hi;
    assign out_lo    = r_out_lo;
    assign out_tag1  = r_out_tag1;
    assign out_tag2  = r_out_tag2;
    assign busy      = (r_state != ST_IDLE);

endmodule
